uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO with a transmit-drain state machine placed between `uart_rx` and `uart_tx` in the serial echo path. Bytes arriving on `rx_ready`/`rx_data` pulses are buffered so back-to-back received characters are not lost while `uart_tx` is busy. Buffered bytes are then issued to `uart_tx` one at a time through its `tx_start`/`tx_busy` handshake.

## Interface

Parameters:
- `DEPTH`, default 16: number of byte entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `wr_en`  in  1: write strobe, one cycle per byte. Connected to `uart_rx.rx_ready`.
- `wr_data`  in  8: byte to buffer. Connected to `uart_rx.rx_data`.
- `tx_busy`  in  1: from `uart_tx`.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8: byte to `uart_tx`. Stable from the `tx_start` cycle until the next `tx_start`.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky flag. Set when a write is dropped.

## Operation

- Storage: `DEPTH` × 8 register array.
- Pointers `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`.
- `count` is a separate register. `empty` and `full` are combinational decodes of `count`.
- Write: on an edge with `wr_en && !full`:
  - `mem[wr_ptr] <= wr_data`
  - `wr_ptr++`
- Write while full: the byte is dropped, `overflow <= 1`, and pointers and `count` are unchanged. A write that is full in the same cycle as a pop is still dropped, because `full` is evaluated before the pop.
- Pop: occurs only in the IDLE→START transition described below. `rd_ptr++`.
- Count update:
  - +1 on accepted write only.
  - −1 on pop only.
  - Unchanged when an accepted write and a pop occur on the same edge.
- Drain FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `!empty && !tx_busy`, then `tx_data <= mem[rd_ptr]`, `tx_start <= 1`, pop, and go to START. Otherwise stay.
  - START: `tx_start <= 0`; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy == 1`, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy == 0`, then go to IDLE.
- `overflow` is cleared only by `rst`.
- Reset, applied on any edge with `rst == 1`, has priority over all other actions:
  - Outputs: `tx_start=0`, `tx_data=8'h00`, `count=0`, `empty=1`, `full=0`, `overflow=0`.
  - Internal: state = IDLE, both pointers = 0.
  - Buffered bytes are discarded. Memory contents need not be cleared.
  - A `wr_en` in the reset cycle is ignored.
- Reset mid-transmission: the character already in flight in `uart_tx` completes on its own. The FSM returns to IDLE, whose `!tx_busy` guard prevents a new `tx_start` until that character ends.

## Timing

- Write latency: a byte written at edge N appears in `count` after edge N.
- Earliest `tx_start`: the pulse is high in the cycle following edge N+1. That is one cycle after `empty` drops, provided the FSM is in IDLE and `tx_busy == 0`.
- `tx_start` is high for exactly one clock per byte.
- `tx_data` is valid in the same cycle as `tx_start`.
- Minimum spacing between `tx_start` pulses: 4 cycles (IDLE→START→WAIT_BUSY→WAIT_DONE→IDLE), plus the `tx_busy` high time.
- `uart_tx` contract: `tx_busy` rises no later than 1 cycle after the `tx_start` cycle. If it never rises, the FSM remains in WAIT_BUSY; this is a system error and no timeout is provided.
- Throughput: bytes leave at the `uart_tx` rate. `wr_en` may arrive every cycle until `full`.

## Test plan

- Single byte: after reset, write 8'h41.
  - `count` reads 1 for one cycle.
  - `tx_start` pulses once with `tx_data == 8'h41`.
  - `count` returns to 0 and `empty == 1`.
- Burst and ordering: with `tx_busy` model = 20 cycles, write 8'h01..8'h05 on consecutive cycles.
  - Five `tx_start` pulses occur in order 01, 02, 03, 04, 05.
  - Each pulse comes only after `tx_busy` has fallen.
  - `overflow == 0` throughout.
- Overflow: hold `tx_busy` high with `DEPTH=16` and write 18 bytes 8'h10..8'h21.
  - `full == 1` and `count == 16`.
  - `overflow == 1`.
  - After releasing `tx_busy`, 8'h10..8'h1F drain in order; 8'h20 and 8'h21 are never sent.
- Simultaneous write and pop: time a write onto the IDLE→START pop edge with `count == 3`.
  - `count` stays at 3.
  - The byte order is preserved across pointer wrap, tested by cycling 40 bytes through a 16-deep FIFO.
- Reset mid-operation: with 6 bytes queued and `tx_busy` high, assert `rst` for 1 cycle.
  - All outputs take their reset values.
  - No `tx_start` occurs until `tx_busy` falls and a new byte is written.
  - The old bytes are never transmitted.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers bytes from uart_rx and drains them one at a
// time through the tx_start/tx_busy handshake.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     tx_busy_i,
  output logic                     tx_start_o,
  output logic [7:0]               tx_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            push, pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

  // full is judged on the pre-edge count, so a write racing a pop while full is dropped
  assign push = wr_en_i && !full_o;
  assign pop  = (state_q == StIdle) && !empty_o && !tx_busy_i;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (wr_en_i && full_o) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            rd_ptr_q   <= rd_ptr_q + AW'(1);
            state_q    <= StStart;
          end
        end
        StStart: begin
          tx_start_q <= 1'b0;
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          // no timeout: a uart_tx that never asserts busy is a system fault
          if (tx_busy_i) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (!tx_busy_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle table for the handshake, then burst,
// overflow, reset and wrap sequences against a simple uart_tx busy model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst, wr_en, man_busy, hold_busy, model_en;
  logic [7:0] wr_data;
  logic       tx_busy, tx_start, empty, full, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int  busy_len = 0;
  int  busy_cnt = 0;
  bit  start_seen = 0;
  int  busy_viol = 0;
  int  wide_viol = 0;
  bit  prev_start = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  assign tx_busy = model_en ? (hold_busy || (busy_cnt > 0)) : man_busy;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow)
  );

  // uart_tx model: busy rises the cycle after tx_start and stays high busy_len cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (start_seen) begin
      busy_cnt   = busy_len;
      start_seen = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    if (tx_start) start_seen = 1;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (tx_start) begin
      q.push_back(tx_data);
      if (tx_busy) busy_viol++;
      if (prev_start) wide_viol++;
    end
    prev_start = tx_start;
  end

  typedef struct packed {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       st;
    logic [7:0] dat;
    logic       ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic b, logic [4:0] c,
                              logic e, logic f, logic s, logic [7:0] t, logic o);
    vec_t v;
    v = {r, w, d, b, c, e, f, s, t, o};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {count, empty, full, tx_start, tx_data, overflow};
  endfunction

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string nm);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, q.size(), n);
  endtask

  task automatic check_seq(input string nm, input logic [7:0] base, input int n);
    chk({nm, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk($sformatf("%s[%0d]", nm, i), {24'h0, q[i]}, {24'h0, base + 8'(i)});
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    //              rst wr  d      busy cnt emp ful st dat    ovf
    vecs[0]  = mk(1, 1, 8'hAA, 0, 0, 1, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 8'h41, 0, 1, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h41, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h41, 0);
    vecs[4]  = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h41, 0);
    vecs[5]  = mk(0, 1, 8'h42, 1, 1, 0, 0, 0, 8'h41, 0);
    vecs[6]  = mk(0, 1, 8'h43, 0, 2, 0, 0, 0, 8'h41, 0);
    vecs[7]  = mk(0, 1, 8'h44, 0, 2, 0, 0, 1, 8'h42, 0);
    vecs[8]  = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h42, 0);
    vecs[9]  = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h42, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 2, 0, 0, 0, 8'h42, 0);
    vecs[11] = mk(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h42, 0);
    vecs[12] = mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h43, 0);
    vecs[13] = mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h43, 0);
    vecs[14] = mk(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h43, 0);
    vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h43, 0);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h44, 0);
    vecs[17] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h44, 0);
    vecs[18] = mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h44, 0);
    vecs[19] = mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h44, 0);

    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; man_busy = 1'b0;
    hold_busy = 1'b0; model_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      rst      = vecs[i].rst;
      wr_en    = vecs[i].wr;
      wr_data  = vecs[i].d;
      man_busy = vecs[i].busy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {15'h0, outs()},
          {15'h0, vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].st, vecs[i].dat, vecs[i].ovf});
    end
    rst = 1'b0; wr_en = 1'b0; man_busy = 1'b0;

    // Burst of five against a 20-cycle transmitter
    q.delete(); busy_viol = 0; wide_viol = 0;
    busy_len = 20; model_en = 1'b1;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    wait_pulses(5, 400, "burst_pulses");
    repeat (30) @(negedge clk);
    check_seq("burst", 8'h01, 5);
    chk("burst_busy_viol", busy_viol, 0);
    chk("burst_wide_pulse", wide_viol, 0);
    chk("burst_overflow", {31'h0, overflow}, 0);

    // Overflow: 18 writes into 16 entries while transmitter is held busy
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    q.delete(); hold_busy = 1'b1; busy_len = 3;
    for (int i = 0; i < 18; i++) write_byte(8'h10 + 8'(i));
    chk("ovf_count", {27'h0, count}, 16);
    chk("ovf_full", {31'h0, full}, 1);
    chk("ovf_flag", {31'h0, overflow}, 1);
    chk("ovf_no_start", q.size(), 0);
    hold_busy = 1'b0;
    wait_pulses(16, 400, "ovf_pulses");
    repeat (40) @(negedge clk);
    check_seq("ovf_drain", 8'h10, 16);
    chk("ovf_sticky", {31'h0, overflow}, 1);
    chk("ovf_empty", {31'h0, empty}, 1);

    // Reset with six bytes queued and transmitter busy
    q.delete(); hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
    chk("rst_pre_count", {27'h0, count}, 6);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_outputs", {15'h0, outs()}, {15'h0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    repeat (10) @(negedge clk);
    hold_busy = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_start", q.size(), 0);
    chk("rst_count", {27'h0, count}, 0);
    write_byte(8'h77);
    wait_pulses(1, 100, "rst_new_pulse");
    repeat (20) @(negedge clk);
    check_seq("rst_new", 8'h77, 1);

    // Write landing on the pop edge with count==3, then 40 bytes across pointer wrap
    q.delete(); busy_viol = 0; wide_viol = 0; hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(8'h80 + 8'(i));
    wr_en = 1'b1; wr_data = 8'h83; hold_busy = 1'b0;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    chk("simul_count", {27'h0, count}, 3);
    chk("simul_start", {31'h0, tx_start}, 1);
    chk("simul_data", {24'h0, tx_data}, 32'h80);
    for (int i = 4; i < 40; i++) begin
      int k = 0;
      while (full && k < 500) begin
        @(negedge clk);
        k++;
      end
      write_byte(8'h80 + 8'(i));
    end
    wait_pulses(40, 1000, "wrap_pulses");
    repeat (20) @(negedge clk);
    check_seq("wrap", 8'h80, 40);
    chk("wrap_overflow", {31'h0, overflow}, 0);
    chk("wrap_busy_viol", busy_viol, 0);
    chk("wrap_wide_pulse", wide_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
